// File: rtl/scan_drv_pkg.sv
// Shared types and constants for the tester-side scan pattern driver.
package scan_drv_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRstLo,
    StRstHi,
    StShReq,
    StShSetup,
    StShHigh,
    StCapSetup,
    StCapHigh,
    StCapHold,
    StFin
  } state_e;

  // Beat layout: {mask1, mask0, exp1, exp0, si1, si0}
  localparam int unsigned SI_LSB   = 0;
  localparam int unsigned EXP_LSB  = 2;
  localparam int unsigned MASK_LSB = 4;

  localparam int unsigned ERR_W = 16;

endpackage

// File: rtl/scan_resp_cmp.sv
// Masked compare of the unloaded scan_do bits with a saturating error counter and
// capture of the first failing beat index.
module scan_resp_cmp
  import scan_drv_pkg::*;
#(
  parameter int unsigned BEAT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              strobe_i,
  input  logic [1:0]        scan_do_i,
  input  logic [1:0]        exp_i,
  input  logic [1:0]        mask_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic              fail_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [BEAT_W-1:0] first_fail_o
);

  logic [1:0]        miss;
  logic [ERR_W:0]    sum;
  logic              fail_d, fail_q;
  logic [ERR_W-1:0]  err_d, err_q;
  logic [BEAT_W-1:0] ff_d, ff_q;

  always_comb begin
    miss   = (scan_do_i ^ exp_i) & mask_i;
    sum    = {1'b0, err_q} + (ERR_W+1)'(miss[0]) + (ERR_W+1)'(miss[1]);
    fail_d = fail_q;
    err_d  = err_q;
    ff_d   = ff_q;
    if (clr_i) begin
      fail_d = 1'b0;
      err_d  = '0;
      ff_d   = '0;
    end else if (strobe_i) begin
      err_d = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
      if ((miss != 2'b00) && !fail_q) begin
        fail_d = 1'b1;
        ff_d   = beat_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q <= 1'b0;
      err_q  <= '0;
      ff_q   <= '0;
    end else begin
      fail_q <= fail_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
    end
  end

  assign fail_o       = fail_q;
  assign err_cnt_o    = err_q;
  assign first_fail_o = ff_q;

endmodule

// File: rtl/scan_pattern_driver.sv
// Tester-side scan sequencer: reset, shift rounds fed by a beat stream, capture pulses,
// and masked response checking of the unloaded chain bits.
module scan_pattern_driver
  import scan_drv_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 64,
  parameter int unsigned PAT_W      = 16,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned BEAT_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  pat_num,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic [5:0]        pat_data,
  output logic              scan_mode,
  output logic              scan_se,
  output logic              scan_clk,
  output logic              scan_rstn,
  output logic [1:0]        scan_di,
  input  logic [1:0]        scan_do,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [BEAT_W-1:0] first_fail
);

  localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned ShW     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  state_e             state_q;
  logic               mode_q, se_q, sclk_q, srstn_q, ready_q, busy_q, done_q;
  logic [1:0]         di_q, exp_q, mask_q;
  logic [RstCntW-1:0] rst_cnt_q;
  logic [ShW-1:0]     shift_q;
  logic [PAT_W-1:0]   round_q, npat_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               cmp_clr, cmp_strobe;

  assign cmp_clr    = (state_q == StIdle) && start && !abort;
  // An abort on the sample edge drops the in-flight compare so results hold.
  assign cmp_strobe = (state_q == StShSetup) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      se_q      <= 1'b0;
      sclk_q    <= 1'b0;
      srstn_q   <= 1'b1;
      di_q      <= 2'b00;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exp_q     <= 2'b00;
      mask_q    <= 2'b00;
      rst_cnt_q <= '0;
      shift_q   <= '0;
      round_q   <= '0;
      npat_q    <= '0;
      beat_q    <= '0;
    end else if (abort && (state_q != StIdle)) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      se_q    <= 1'b0;
      sclk_q  <= 1'b0;
      srstn_q <= 1'b1;
      di_q    <= 2'b00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            npat_q    <= pat_num;
            beat_q    <= '0;
            round_q   <= '0;
            shift_q   <= '0;
            rst_cnt_q <= '0;
            busy_q    <= 1'b1;
            mode_q    <= 1'b1;
            srstn_q   <= 1'b0;
            state_q   <= StRstLo;
          end
        end
        StRstLo: begin
          if (rst_cnt_q == RstCntW'(RST_CYCLES - 1)) begin
            rst_cnt_q <= '0;
            srstn_q   <= 1'b1;
            state_q   <= StRstHi;
          end else begin
            rst_cnt_q <= rst_cnt_q + RstCntW'(1);
          end
        end
        StRstHi: begin
          if (rst_cnt_q == RstCntW'(1)) begin
            se_q    <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StShReq;
          end else begin
            rst_cnt_q <= rst_cnt_q + RstCntW'(1);
          end
        end
        StShReq: begin
          if (pat_valid && ready_q) begin
            ready_q <= 1'b0;
            di_q    <= pat_data[SI_LSB +: 2];
            exp_q   <= pat_data[EXP_LSB +: 2];
            mask_q  <= pat_data[MASK_LSB +: 2];
            state_q <= StShSetup;
          end
        end
        StShSetup: begin
          sclk_q  <= 1'b1;
          state_q <= StShHigh;
        end
        StShHigh: begin
          sclk_q <= 1'b0;
          beat_q <= beat_q + BEAT_W'(1);
          if (shift_q != ShW'(CHAIN_LEN - 1)) begin
            shift_q <= shift_q + ShW'(1);
            ready_q <= 1'b1;
            state_q <= StShReq;
          end else if (round_q < npat_q) begin
            se_q    <= 1'b0;
            state_q <= StCapSetup;
          end else begin
            done_q  <= 1'b1;
            mode_q  <= 1'b0;
            se_q    <= 1'b0;
            di_q    <= 2'b00;
            state_q <= StFin;
          end
        end
        StCapSetup: begin
          sclk_q  <= 1'b1;
          state_q <= StCapHigh;
        end
        StCapHigh: begin
          sclk_q  <= 1'b0;
          state_q <= StCapHold;
        end
        StCapHold: begin
          round_q <= round_q + PAT_W'(1);
          shift_q <= '0;
          se_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= StShReq;
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  scan_resp_cmp #(
    .BEAT_W (BEAT_W)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (cmp_clr),
    .strobe_i     (cmp_strobe),
    .scan_do_i    (scan_do),
    .exp_i        (exp_q),
    .mask_i       (mask_q),
    .beat_i       (beat_q),
    .fail_o       (fail),
    .err_cnt_o    (err_cnt),
    .first_fail_o (first_fail)
  );

  assign scan_mode = mode_q;
  assign scan_se   = se_q;
  assign scan_clk  = sclk_q;
  assign scan_rstn = srstn_q;
  assign scan_di   = di_q;
  assign pat_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Directed bench: a 4-flop two-chain device model answers the scan pins; capture inverts
// the chains so the unload round returns the complement of what was shifted in.
module tb_scan_pattern_driver;

  logic        clk = 1'b0;
  logic        rst, start, abort, pat_valid, pat_ready;
  logic [15:0] pat_num;
  logic [5:0]  pat_data;
  logic        scan_mode, scan_se, scan_clk, scan_rstn, busy, done, fail;
  logic [1:0]  scan_di, scan_do, flip;
  logic [15:0] err_cnt;
  logic [23:0] first_fail;
  logic [3:0]  ch0, ch1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  pats [16];
  logic [15:0] exp_err [4];
  logic [1:0]  flip_val, garb_mask;
  int          nb, flip_beat, stall_at, abort_at, rst_beat, cyc, cap_pulses, sh_pulses;
  bit          preload, chk_err, got_done;

  always #5 clk = ~clk;

  scan_pattern_driver #(
    .CHAIN_LEN  (4),
    .PAT_W      (16),
    .RST_CYCLES (8),
    .BEAT_W     (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pat_num    (pat_num),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .scan_mode  (scan_mode),
    .scan_se    (scan_se),
    .scan_clk   (scan_clk),
    .scan_rstn  (scan_rstn),
    .scan_di    (scan_di),
    .scan_do    (scan_do),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  // Device under scan: shift on scan_clk with se=1, capture (invert) with se=0.
  always @(posedge scan_clk or negedge scan_rstn) begin
    if (!scan_rstn) begin
      ch0 <= 4'h0;
      ch1 <= 4'h0;
    end else if (scan_se) begin
      ch0 <= {ch0[2:0], scan_di[0]};
      ch1 <= {ch1[2:0], scan_di[1]};
    end else begin
      ch0 <= ~ch0;
      ch1 <= ~ch1;
    end
  end

  assign scan_do = {ch1[3], ch0[3]} ^ flip;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string ph);
    check({ph, "_scan_mode"}, 32'(scan_mode), 0);
    check({ph, "_scan_se"},   32'(scan_se),   0);
    check({ph, "_scan_clk"},  32'(scan_clk),  0);
    check({ph, "_scan_rstn"}, 32'(scan_rstn), 1);
    check({ph, "_scan_di"},   32'(scan_di),   0);
    check({ph, "_pat_ready"}, 32'(pat_ready), 0);
    check({ph, "_busy"},      32'(busy),      0);
    check({ph, "_done"},      32'(done),      0);
  endtask

  task automatic load_base();
    for (int i = 0; i < 16; i++) pats[i] = 6'b00_00_00;
    pats[0] = 6'b11_00_01;
    pats[1] = 6'b11_00_10;
    pats[2] = 6'b11_00_11;
    pats[3] = 6'b11_00_01;
    pats[4] = 6'b11_10_00;
    pats[5] = 6'b11_01_00;
    pats[6] = 6'b11_00_00;
    pats[7] = 6'b11_10_00;
    nb = 8; pat_num = 16'd1;
    flip_beat = -1; flip_val = 2'b00; garb_mask = 2'b00;
    stall_at = -1; abort_at = -1; rst_beat = -1; preload = 1'b0; chk_err = 1'b0;
  endtask

  task automatic run_seq();
    int         idx, stall;
    bit         hs, aborted;
    logic [1:0] ei;
    idx = 0; stall = 0; aborted = 1'b0;
    cyc = 0; got_done = 1'b0; cap_pulses = 0; sh_pulses = 0;
    pat_data = pats[0]; pat_valid = 1'b1; flip = 2'b00;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    check("start_busy",  32'(busy),       1);
    check("start_fail",  32'(fail),       0);
    check("start_err",   32'(err_cnt),    0);
    check("start_ff",    32'(first_fail), 0);
    check("start_mode",  32'(scan_mode),  1);
    check("start_rstn",  32'(scan_rstn),  0);
    while (cyc < 200) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (scan_clk && scan_se) sh_pulses++;
      if (scan_clk && !scan_se) cap_pulses++;
      if (preload && cyc == 3) force dut.u_cmp.err_q = 16'hFFFC;
      if (preload && cyc == 4) release dut.u_cmp.err_q;
      if (chk_err && scan_clk && idx >= 1) begin
        ei = 2'(idx - 1);
        check("err_beat", 32'(err_cnt), 32'(exp_err[ei]));
      end
      if (rst_beat >= 0 && idx == rst_beat + 1 && scan_clk) begin
        rst = 1'b1; #1;
        check_idle("async_rst");
        check("async_rst_fail", 32'(fail),       0);
        check("async_rst_err",  32'(err_cnt),    0);
        check("async_rst_ff",   32'(first_fail), 0);
        break;
      end
      if (abort) begin
        abort = 1'b0; aborted = 1'b1;
        check_idle("abort");
      end else if (!aborted && abort_at >= 0 && idx == abort_at + 1) begin
        abort = 1'b1;
      end
      flip = (idx == flip_beat + 1) ? flip_val : 2'b00;
      flip = flip | (2'($urandom) & garb_mask);
      if (idx == stall_at && stall < 10) begin
        stall++;
        pat_valid = 1'b0;
        if (stall >= 3) begin
          check("stall_sclk",  32'(scan_clk),  0);
          check("stall_ready", 32'(pat_ready), 1);
          flip = 2'b11;
        end
      end else begin
        pat_valid = (idx < nb);
        pat_data  = pats[idx[3:0]];
      end
      @(negedge clk); hs = pat_valid && pat_ready;
      @(posedge clk); #1; cyc++;
      if (hs) idx++;
    end
    pat_valid = 1'b0; flip = 2'b00; abort = 1'b0;
  endtask

  task automatic post_checks(input int exp_cyc, input int exp_e, input int exp_f, input int exp_ff);
    check("got_done",     32'(got_done),   1);
    check("done_cycles",  32'(cyc),        32'(exp_cyc));
    check("fail",         32'(fail),       32'(exp_f));
    check("err_cnt",      32'(err_cnt),    32'(exp_e));
    if (exp_f != 0) check("first_fail", 32'(first_fail), 32'(exp_ff));
    check("shift_pulses", 32'(sh_pulses),  32'(nb));
    check("cap_pulses",   32'(cap_pulses), 32'(pat_num));
    @(posedge clk); #1;
    check_idle("after_done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pat_num = 16'd0;
    pat_valid = 1'b0; pat_data = 6'd0; flip = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_fail", 32'(fail),       0);
    check("reset_err",  32'(err_cnt),    0);
    check("reset_ff",   32'(first_fail), 0);
    @(negedge clk); rst = 1'b0;

    // Clean two-round run
    load_base();
    run_seq();
    post_checks(38, 0, 0, 0);

    // Chain-1 flipped on beat 5, then both chains
    load_base(); flip_beat = 5; flip_val = 2'b10;
    run_seq();
    post_checks(38, 1, 1, 5);
    load_base(); flip_beat = 5; flip_val = 2'b11;
    run_seq();
    post_checks(38, 2, 1, 5);

    // Ten-cycle stall before beat 2 with garbage on scan_do while waiting
    load_base(); stall_at = 2;
    run_seq();
    post_checks(46, 0, 0, 0);

    // All masked off with garbage, then only chain 0 compared
    load_base(); garb_mask = 2'b11;
    for (int i = 0; i < 8; i++) pats[i][5:4] = 2'b00;
    run_seq();
    post_checks(38, 0, 0, 0);
    load_base(); garb_mask = 2'b10; flip_beat = 5; flip_val = 2'b01;
    for (int i = 0; i < 8; i++) pats[i][5:4] = 2'b01;
    run_seq();
    post_checks(38, 1, 1, 5);

    // Abort during beat 3 after a beat-1 mismatch; results must hold
    load_base(); flip_beat = 1; flip_val = 2'b01; abort_at = 3;
    run_seq();
    check("abort_no_done", 32'(got_done),   0);
    check("abort_fail",    32'(fail),       1);
    check("abort_err",     32'(err_cnt),    1);
    check("abort_ff",      32'(first_fail), 1);

    // start with abort: abort wins, nothing cleared
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy),    0);
    check("start_abort_fail", 32'(fail),    1);
    check("start_abort_err",  32'(err_cnt), 1);

    // Fresh start clears and runs clean
    load_base();
    run_seq();
    post_checks(38, 0, 0, 0);

    // Saturation from a preloaded 0xFFFC, then async reset while scan_clk is high
    load_base(); nb = 4; pat_num = 16'd0; preload = 1'b1; chk_err = 1'b1; rst_beat = 3;
    for (int i = 0; i < 4; i++) pats[i] = 6'b11_11_00;
    exp_err[0] = 16'hFFFE; exp_err[1] = 16'hFFFF;
    exp_err[2] = 16'hFFFF; exp_err[3] = 16'hFFFF;
    run_seq();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
